// File: rtl/vxe_txnres_status_queue.sv
// Transaction response status queue: small FIFO of {txnid, rnw, err} records
// with sticky error flag and per-direction accepted-response counters.
module vxe_txnres_status_queue #(
  parameter int TXNID_W = 6,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [TXNID_W+2:0]     i_res_vec_txn,
  input  logic                   i_res_valid,
  output logic                   o_res_rdy,
  output logic [TXNID_W-1:0]     o_txnid,
  output logic                   o_rnw,
  output logic [1:0]             o_err,
  output logic                   o_valid,
  input  logic                   i_rdy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_err_seen,
  input  logic                   i_err_clr,
  output logic [CNT_W-1:0]       o_rd_cnt,
  output logic [CNT_W-1:0]       o_wr_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int VEC_W = TXNID_W + 3;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_STEP = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] RSP_ONE  = CNT_W'(1);

  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_err_seen;

  logic             w_res_rdy;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic [VEC_W-1:0] w_head;
  logic             w_push_rnw;
  logic             w_push_err;

  // Handshake qualifiers derived from registered occupancy only
  always_comb begin
    w_res_rdy  = (r_count != FULL_CNT);
    w_valid    = (r_count != {(PTR_W+1){1'b0}});
    w_push     = i_res_valid && w_res_rdy;
    w_pop      = w_valid && i_rdy;
    w_head     = r_mem[r_rptr];
    w_push_rnw = i_res_vec_txn[2];
    w_push_err = (i_res_vec_txn[1:0] != 2'b00);
  end

  // Entry storage and write pointer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {VEC_W{1'b0}};
      end
      r_wptr <= {PTR_W{1'b0}};
    end else if (w_push) begin
      r_mem[r_wptr] <= i_res_vec_txn;
      r_wptr        <= r_wptr + PTR_ONE;
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer advances on each pop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rptr <= {PTR_W{1'b0}};
    end else if (w_pop) begin
      r_rptr <= r_rptr + PTR_ONE;
    end else begin
      r_rptr <= r_rptr;
    end
  end

  // Occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= {(PTR_W+1){1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_STEP;
        2'b01:   r_count <= r_count - CNT_STEP;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accepted-response counters split by direction, wrapping naturally
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_cnt <= {CNT_W{1'b0}};
      r_wr_cnt <= {CNT_W{1'b0}};
    end else if (w_push && w_push_rnw) begin
      r_rd_cnt <= r_rd_cnt + RSP_ONE;
    end else if (w_push) begin
      r_wr_cnt <= r_wr_cnt + RSP_ONE;
    end else begin
      r_rd_cnt <= r_rd_cnt;
      r_wr_cnt <= r_wr_cnt;
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err_seen <= 1'b0;
    end else if (w_push && w_push_err) begin
      r_err_seen <= 1'b1;
    end else if (i_err_clr) begin
      r_err_seen <= 1'b0;
    end else begin
      r_err_seen <= r_err_seen;
    end
  end

  // Head fields are forced to zero while the queue is empty
  always_comb begin
    o_txnid = {TXNID_W{1'b0}};
    o_rnw   = 1'b0;
    o_err   = 2'b00;
    if (w_valid) begin
      o_txnid = w_head[VEC_W-1:3];
      o_rnw   = w_head[2];
      o_err   = w_head[1:0];
    end else begin
      o_txnid = {TXNID_W{1'b0}};
      o_rnw   = 1'b0;
      o_err   = 2'b00;
    end
  end

  assign o_res_rdy  = w_res_rdy;
  assign o_valid    = w_valid;
  assign o_count    = r_count;
  assign o_err_seen = r_err_seen;
  assign o_rd_cnt   = r_rd_cnt;
  assign o_wr_cnt   = r_wr_cnt;

endmodule
